// File: rtl/instr_adder_pkg.sv
// Shared types and constants for the instrumented_adder sequencer.
// Control bit positions follow the la1 control layout so sequencer outputs can share that bus.
package instr_adder_pkg;

  localparam int SEL_W  = 8;
  localparam int BIT_W  = 3;
  localparam int CNT_W  = 33;
  localparam int CTRL_W = 7;

  localparam int CTRL_RESET        = 0;
  localparam int CTRL_STOP_B       = 1;
  localparam int CTRL_EXTRA_INV    = 2;
  localparam int CTRL_BYPASS_B     = 3;
  localparam int CTRL_CONTROL_B    = 4;
  localparam int CTRL_COUNTER_EN   = 5;
  localparam int CTRL_COUNTER_LOAD = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST,
    ST_LOAD,
    ST_RUN,
    ST_SETTLE,
    ST_OUT
  } state_e;

  // One-cold select selecting the given sum bit.
  function automatic logic [SEL_W-1:0] sel_b(input logic [BIT_W-1:0] b);
    return ~(SEL_W'(1) << b);
  endfunction

endpackage

// File: rtl/seq_delay_counter.sv
// Loadable counter: counts up in RUN (timeout compare done by the caller), otherwise
// counts down and saturates at zero. Load takes effect on the next edge.
module seq_delay_counter
  import instr_adder_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             up_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (up_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/instrumented_adder_sequencer.sv
// Sweeps sum bits of instrumented_adder: reset, load, run until done, settle, then offer the
// ring count on a valid/ready port; the sweep stalls in OUT while result_ready is low.
module instrumented_adder_sequencer
  import instr_adder_pkg::*;
#(
  parameter int RESET_CYCLES   = 4,
  parameter int SETTLE_CYCLES  = 8,
  parameter int TIMEOUT_MARGIN = 1024
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start,
  input  logic              abort,
  input  logic [31:0]       cfg_integration_time,
  input  logic [SEL_W-1:0]  cfg_a_input,
  input  logic [SEL_W-1:0]  cfg_b_input,
  input  logic [BIT_W-1:0]  cfg_bit_first,
  input  logic [BIT_W-1:0]  cfg_bit_last,
  input  logic              cfg_bypass,
  input  logic              cfg_extra_inverter,
  input  logic              cfg_control,
  output logic              busy,
  output logic              error,
  output logic              dut_reset,
  output logic              dut_stop_b,
  output logic              dut_extra_inverter,
  output logic              dut_bypass_b,
  output logic              dut_control_b,
  output logic [SEL_W-1:0]  dut_a_input_ext_bit_b,
  output logic [SEL_W-1:0]  dut_a_input_ring_bit_b,
  output logic [SEL_W-1:0]  dut_s_output_bit_b,
  output logic              dut_counter_enable,
  output logic              dut_counter_load,
  output logic [31:0]       dut_integration_time,
  output logic [SEL_W-1:0]  dut_a_input,
  output logic [SEL_W-1:0]  dut_b_input,
  input  logic              dut_done,
  input  logic [31:0]       dut_ring_count,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [BIT_W-1:0]  result_bit,
  output logic [31:0]       result_count,
  output logic              result_last
);

  localparam logic [CNT_W-1:0] RST_LD    = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             error_q, error_d;
  logic [31:0]      count_q, count_d;
  logic             cfg_en;

  logic [31:0]      integ_q;
  logic [SEL_W-1:0] a_q, b_q;
  logic [BIT_W-1:0] last_q;
  logic             single_q, bypass_q, xinv_q, control_q;

  logic             dly_ld, dly_zero;
  logic [CNT_W-1:0] dly_ld_val, dly_cnt, limit;
  logic             last_bit;
  logic [CTRL_W-1:0] ctrl;

  assign limit    = {1'b0, integ_q} + CNT_W'(TIMEOUT_MARGIN);
  assign last_bit = single_q || (bit_q == last_q);

  seq_delay_counter u_dly (
    .clk_i      (wb_clk_i),
    .rst_i      (wb_rst_i),
    .load_i     (dly_ld),
    .load_val_i (dly_ld_val),
    .up_i       (state_q == ST_RUN),
    .cnt_o      (dly_cnt),
    .zero_o     (dly_zero)
  );

  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    error_d    = error_q;
    count_d    = count_q;
    cfg_en     = 1'b0;
    dly_ld     = 1'b0;
    dly_ld_val = '0;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d    = ST_RST;
        cfg_en     = 1'b1;
        bit_d      = cfg_bit_first;
        error_d    = 1'b0;
        dly_ld     = 1'b1;
        dly_ld_val = RST_LD;
      end
      ST_RST: if (dly_zero) state_d = ST_LOAD;
      ST_LOAD: begin
        state_d = ST_RUN;
        dly_ld  = 1'b1;
      end
      // done wins over a timeout landing in the same cycle
      ST_RUN: if (dut_done) begin
        state_d    = ST_SETTLE;
        dly_ld     = 1'b1;
        dly_ld_val = SETTLE_LD;
      end else if (dly_cnt + CNT_W'(1) == limit) begin
        state_d = ST_IDLE;
        error_d = 1'b1;
      end
      ST_SETTLE: if (dly_zero) begin
        state_d = ST_OUT;
        count_d = dut_ring_count;
      end
      ST_OUT: if (result_ready) begin
        if (last_bit) begin
          state_d = ST_IDLE;
        end else begin
          state_d    = ST_RST;
          bit_d      = bit_q + BIT_W'(1);
          dly_ld     = 1'b1;
          dly_ld_val = RST_LD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d = ST_IDLE;
      bit_d   = bit_q;
      error_d = error_q;
      count_d = count_q;
      cfg_en  = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      bit_q     <= '0;
      error_q   <= 1'b0;
      count_q   <= '0;
      integ_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      last_q    <= '0;
      single_q  <= 1'b0;
      bypass_q  <= 1'b0;
      xinv_q    <= 1'b0;
      control_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      error_q <= error_d;
      count_q <= count_d;
      if (cfg_en) begin
        integ_q   <= cfg_integration_time;
        a_q       <= cfg_a_input;
        b_q       <= cfg_b_input;
        last_q    <= cfg_bit_last;
        single_q  <= (cfg_bit_last < cfg_bit_first);
        bypass_q  <= cfg_bypass;
        xinv_q    <= cfg_extra_inverter;
        control_q <= cfg_control;
      end
    end
  end

  // IDLE presents the reset-state control word regardless of latched config.
  always_comb begin
    ctrl                 = '0;
    ctrl[CTRL_RESET]     = 1'b1;
    ctrl[CTRL_BYPASS_B]  = 1'b1;
    ctrl[CTRL_CONTROL_B] = 1'b1;
    if (state_q != ST_IDLE) begin
      ctrl[CTRL_EXTRA_INV] = xinv_q;
      ctrl[CTRL_BYPASS_B]  = ~bypass_q;
      ctrl[CTRL_CONTROL_B] = ~control_q;
    end
    case (state_q)
      ST_LOAD: begin
        ctrl[CTRL_RESET]        = 1'b0;
        ctrl[CTRL_COUNTER_LOAD] = 1'b1;
      end
      ST_RUN: begin
        ctrl[CTRL_RESET]      = 1'b0;
        ctrl[CTRL_STOP_B]     = 1'b1;
        ctrl[CTRL_COUNTER_EN] = 1'b1;
      end
      ST_SETTLE, ST_OUT: ctrl[CTRL_RESET] = 1'b0;
      default: ;
    endcase
  end

  assign busy                   = (state_q != ST_IDLE);
  assign error                  = error_q;
  assign dut_reset              = ctrl[CTRL_RESET];
  assign dut_stop_b             = ctrl[CTRL_STOP_B];
  assign dut_extra_inverter     = ctrl[CTRL_EXTRA_INV];
  assign dut_bypass_b           = ctrl[CTRL_BYPASS_B];
  assign dut_control_b          = ctrl[CTRL_CONTROL_B];
  assign dut_counter_enable     = ctrl[CTRL_COUNTER_EN];
  assign dut_counter_load       = ctrl[CTRL_COUNTER_LOAD];
  assign dut_a_input_ext_bit_b  = '1;
  assign dut_a_input_ring_bit_b = busy ? sel_b(bit_q) : '1;
  assign dut_s_output_bit_b     = busy ? sel_b(bit_q) : '1;
  assign dut_integration_time   = busy ? integ_q : '0;
  assign dut_a_input            = busy ? a_q : '0;
  assign dut_b_input            = busy ? b_q : '0;
  assign result_valid           = (state_q == ST_OUT);
  assign result_bit             = bit_q;
  assign result_count           = count_q;
  assign result_last            = last_bit;

endmodule

// File: tb/tb_instrumented_adder_sequencer.sv
// Randomized scoreboard bench for instrumented_adder_sequencer with a behavioural
// model of the instrumented_adder counter block.
module tb_instrumented_adder_sequencer;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        start, abort;
  logic [31:0] cfg_integration_time;
  logic [7:0]  cfg_a_input, cfg_b_input;
  logic [2:0]  cfg_bit_first, cfg_bit_last;
  logic        cfg_bypass, cfg_extra_inverter, cfg_control;
  logic        busy, error, dut_reset, dut_stop_b, dut_extra_inverter, dut_bypass_b, dut_control_b;
  logic [7:0]  dut_a_input_ext_bit_b, dut_a_input_ring_bit_b, dut_s_output_bit_b;
  logic        dut_counter_enable, dut_counter_load;
  logic [31:0] dut_integration_time;
  logic [7:0]  dut_a_input, dut_b_input;
  logic        dut_done;
  logic [31:0] dut_ring_count;
  logic        result_valid, result_ready;
  logic [2:0]  result_bit;
  logic [31:0] result_count;
  logic        result_last;

  instrumented_adder_sequencer dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start(start), .abort(abort),
    .cfg_integration_time(cfg_integration_time), .cfg_a_input(cfg_a_input),
    .cfg_b_input(cfg_b_input), .cfg_bit_first(cfg_bit_first), .cfg_bit_last(cfg_bit_last),
    .cfg_bypass(cfg_bypass), .cfg_extra_inverter(cfg_extra_inverter), .cfg_control(cfg_control),
    .busy(busy), .error(error), .dut_reset(dut_reset), .dut_stop_b(dut_stop_b),
    .dut_extra_inverter(dut_extra_inverter), .dut_bypass_b(dut_bypass_b),
    .dut_control_b(dut_control_b), .dut_a_input_ext_bit_b(dut_a_input_ext_bit_b),
    .dut_a_input_ring_bit_b(dut_a_input_ring_bit_b), .dut_s_output_bit_b(dut_s_output_bit_b),
    .dut_counter_enable(dut_counter_enable), .dut_counter_load(dut_counter_load),
    .dut_integration_time(dut_integration_time), .dut_a_input(dut_a_input),
    .dut_b_input(dut_b_input), .dut_done(dut_done), .dut_ring_count(dut_ring_count),
    .result_valid(result_valid), .result_ready(result_ready), .result_bit(result_bit),
    .result_count(result_count), .result_last(result_last)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model of the measured block: counts enable cycles after a load, raises done once the
  // integration time is reached, and only shows a settled ring count two cycles after stop.
  logic [31:0] en_cnt, integ_m;
  logic [7:0]  stop_cnt;
  logic        no_done = 1'b0;
  logic [31:0] ring_tab [8];

  always @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      en_cnt <= 0; integ_m <= 0; stop_cnt <= 0;
    end else begin
      if (dut_reset) en_cnt <= 0;
      else if (dut_counter_load) begin en_cnt <= 0; integ_m <= dut_integration_time; end
      else if (dut_counter_enable) en_cnt <= en_cnt + 1;
      if (dut_stop_b || dut_reset) stop_cnt <= 0;
      else if (stop_cnt != 8'hFF) stop_cnt <= stop_cnt + 1;
    end
  end

  function automatic int sel_idx(input logic [7:0] s);
    for (int i = 0; i < 8; i++) if (!s[i]) return i;
    return 0;
  endfunction

  assign dut_done       = !no_done && !dut_reset && (en_cnt >= integ_m);
  assign dut_ring_count = (stop_cnt >= 2) ? ring_tab[sel_idx(dut_s_output_bit_b)]
                                          : (32'hDEAD_0000 | 32'(stop_cnt));

  typedef struct packed {logic [2:0] b; logic [31:0] c; logic l;} exp_t;
  exp_t sb[$];
  exp_t e;

  always @(negedge wb_clk_i) begin
    if (result_valid && result_ready) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL sb_unexpected: got bit %0d count 0x%0h, no result expected", result_bit, result_count);
      end else begin
        e = sb.pop_front();
        check("res_bit", result_bit, e.b);
        check("res_count", result_count, e.c);
        check("res_last", result_last, e.l);
      end
    end
  end

  int rst_cyc = 0, load_cyc = 0, en_cyc = 0, valid_cyc = 0;
  logic [7:0]  run_a, run_b, run_s_b, run_ring_b, run_ext_b;
  logic [31:0] run_integ;
  logic [2:0]  run_ctl;
  always @(negedge wb_clk_i) begin
    if (busy && dut_reset) rst_cyc++;
    if (dut_counter_load) load_cyc++;
    if (dut_counter_enable) en_cyc++;
    if (result_valid) valid_cyc++;
    if (dut_stop_b) begin
      run_a = dut_a_input; run_b = dut_b_input; run_integ = dut_integration_time;
      run_s_b = dut_s_output_bit_b; run_ring_b = dut_a_input_ring_bit_b;
      run_ext_b = dut_a_input_ext_bit_b;
      run_ctl = {dut_extra_inverter, dut_bypass_b, dut_control_b};
    end
  end

  int ready_mode = 0;  // 0 always ready, 1 random, 2 held low
  initial begin
    result_ready = 1'b0;
    forever begin
      @(posedge wb_clk_i); #1;
      case (ready_mode)
        0: result_ready = 1'b1;
        1: result_ready = 1'($urandom_range(0, 1));
        default: result_ready = 1'b0;
      endcase
    end
  end

  logic [7:0]  exp_a, exp_b;
  logic [31:0] exp_integ;
  logic [2:0]  exp_ctl;
  int r0, l0, e0, v0;

  task automatic snap();
    r0 = rst_cyc; l0 = load_cyc; e0 = en_cyc; v0 = valid_cyc;
  endtask

  task automatic launch(input logic [2:0] first, input logic [2:0] last, input logic [31:0] integ,
                        input bit expect_res, input bit keep_ring);
    cfg_bit_first = first; cfg_bit_last = last; cfg_integration_time = integ;
    cfg_a_input = 8'($urandom); cfg_b_input = 8'($urandom);
    cfg_bypass = 1'($urandom_range(0, 1)); cfg_extra_inverter = 1'($urandom_range(0, 1));
    cfg_control = 1'($urandom_range(0, 1));
    exp_a = cfg_a_input; exp_b = cfg_b_input; exp_integ = integ;
    exp_ctl = {cfg_extra_inverter, ~cfg_bypass, ~cfg_control};
    if (!keep_ring) for (int i = 0; i < 8; i++) ring_tab[i] = $urandom;
    if (expect_res) begin
      if (last < first) sb.push_back(exp_t'{b: first, c: ring_tab[first], l: 1'b1});
      else for (int i = int'(first); i <= int'(last); i++)
        sb.push_back(exp_t'{b: 3'(i), c: ring_tab[i], l: (i == int'(last))});
    end
    start = 1'b1;
    @(negedge wb_clk_i);
    start = 1'b0;
    // scramble inputs: the sweep must run on the latched copy
    cfg_a_input = 8'($urandom); cfg_b_input = 8'($urandom); cfg_integration_time = $urandom;
    cfg_bit_first = 3'($urandom); cfg_bit_last = 3'($urandom);
    cfg_bypass = ~cfg_bypass; cfg_control = ~cfg_control; cfg_extra_inverter = ~cfg_extra_inverter;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin @(negedge wb_clk_i); n++; end
    if (busy) begin
      tests++; fails++;
      $display("FAIL %s: still busy after %0d cycles", name, budget);
    end
  endtask

  task automatic wait_sig(input string name, input int which, input logic lvl, input int budget);
    int n = 0;
    while (((which == 0) ? dut_stop_b : result_valid) !== lvl && n < budget) begin
      @(negedge wb_clk_i); n++;
    end
    if (n >= budget) begin
      tests++; fails++;
      $display("FAIL %s: signal did not reach %0d within %0d cycles", name, lvl, budget);
    end
  endtask

  task automatic check_sweep(input string p, input int nbits, input logic [2:0] lastbit);
    logic [7:0] sel;
    sel = ~(8'd1 << lastbit);
    check({p, "_sb_drained"}, sb.size(), 0);
    check({p, "_rst_cycles"}, rst_cyc - r0, 4 * nbits);
    check({p, "_load_pulses"}, load_cyc - l0, nbits);
    check({p, "_run_a_b"}, {run_a, run_b}, {exp_a, exp_b});
    check({p, "_run_integ"}, run_integ, exp_integ);
    check({p, "_run_ctl"}, run_ctl, exp_ctl);
    check({p, "_run_sel"}, {run_s_b, run_ring_b, run_ext_b}, {sel, sel, 8'hFF});
  endtask

  initial begin
    int integ, f, l, nb;
    logic [2:0]  b0;
    logic [31:0] c0;
    bit stable;
    start = 0; abort = 0; wb_rst_i = 1'b1;
    cfg_integration_time = 0; cfg_a_input = 0; cfg_b_input = 0; cfg_bit_first = 0;
    cfg_bit_last = 0; cfg_bypass = 0; cfg_extra_inverter = 0; cfg_control = 0;
    for (int i = 0; i < 8; i++) ring_tab[i] = 0;
    repeat (3) @(negedge wb_clk_i);
    check("reset_ctrl", {busy, error, result_valid, dut_reset, dut_stop_b, dut_counter_enable,
          dut_counter_load, dut_bypass_b, dut_control_b, dut_extra_inverter}, 10'b0001000110);
    check("reset_sel", {dut_a_input_ext_bit_b, dut_a_input_ring_bit_b, dut_s_output_bit_b}, 24'hFFFFFF);
    check("reset_data", {dut_integration_time, dut_a_input, dut_b_input}, 48'h0);
    wb_rst_i = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    check("idle_after_reset", {busy, result_valid, dut_reset}, 3'b001);

    // single bit 3, known ring count
    ring_tab[3] = 32'h1234;
    snap();
    launch(3'd3, 3'd3, 100, 1'b1, 1'b1);
    wait_idle("single", 2000);
    check_sweep("single", 1, 3'd3);
    check("single_en_cycles", en_cyc - e0, 101);
    check("single_valid_cycles", valid_cyc - v0, 1);

    // full sweep with ready always high
    integ = $urandom_range(20, 60);
    snap();
    launch(3'd0, 3'd7, 32'(integ), 1'b1, 1'b0);
    wait_idle("sweep", 4000);
    check_sweep("sweep", 8, 3'd7);
    check("sweep_en_cycles", en_cyc - e0, 8 * (integ + 1));
    check("sweep_valid_cycles", valid_cyc - v0, 8);

    // backpressure in OUT
    ready_mode = 2;
    snap();
    launch(3'd2, 3'd3, 30, 1'b1, 1'b0);
    wait_sig("bp_valid", 1, 1'b1, 500);
    b0 = result_bit; c0 = result_count; stable = 1;
    repeat (20) begin
      @(negedge wb_clk_i);
      if (!result_valid || result_bit !== b0 || result_count !== c0 || dut_reset) stable = 0;
    end
    check("bp_hold", stable, 1);
    check("bp_bit", b0, 3'd2);
    check("bp_no_rst", rst_cyc - r0, 4);
    ready_mode = 0;
    wait_idle("bp", 1000);
    check_sweep("bp", 2, 3'd3);

    // timeout
    no_done = 1'b1;
    snap();
    launch(3'd5, 3'd5, 10, 1'b0, 1'b0);
    wait_idle("timeout", 3000);
    check("timeout_error", error, 1);
    check("timeout_en_cycles", en_cyc - e0, 1034);
    check("timeout_stop_b", dut_stop_b, 0);
    check("timeout_no_valid", valid_cyc - v0, 0);
    no_done = 1'b0;

    // abort while idle, and abort together with start
    abort = 1'b1; @(negedge wb_clk_i); abort = 1'b0;
    check("abort_idle_err", error, 1);
    start = 1'b1; abort = 1'b1; @(negedge wb_clk_i); start = 1'b0; abort = 1'b0;
    @(negedge wb_clk_i);
    check("start_abort_same", {busy, error}, 2'b01);

    // abort in RUN
    launch(3'd1, 3'd5, 200, 1'b1, 1'b0);
    check("start_clears_err", error, 0);
    wait_sig("abort_run_wait", 0, 1'b1, 100);
    abort = 1'b1; @(negedge wb_clk_i); abort = 1'b0;
    check("abort_run", {busy, result_valid, dut_counter_enable, dut_stop_b, dut_reset, error}, 6'b000010);
    sb.delete();
    snap();
    repeat (20) @(negedge wb_clk_i);
    check("abort_run_quiet", {busy, 32'(valid_cyc - v0)}, 33'h0);

    // abort in OUT discards the pending result
    ready_mode = 2;
    launch(3'd4, 3'd6, 15, 1'b1, 1'b0);
    wait_sig("abort_out_wait", 1, 1'b1, 500);
    abort = 1'b1; @(negedge wb_clk_i); abort = 1'b0;
    check("abort_out", {busy, result_valid, dut_counter_enable, dut_reset}, 4'b0001);
    sb.delete();
    ready_mode = 0;

    // randomized sweeps including reversed ranges and random ready
    ready_mode = 1;
    for (int k = 0; k < 6; k++) begin
      f = $urandom_range(0, 7); l = $urandom_range(0, 7);
      nb = (l < f) ? 1 : l - f + 1;
      snap();
      launch(3'(f), 3'(l), 32'($urandom_range(0, 40)), 1'b1, 1'b0);
      wait_idle("rand", 4000);
      check_sweep("rand", nb, (l < f) ? 3'(f) : 3'(l));
    end
    ready_mode = 0;

    // asynchronous reset during SETTLE
    launch(3'd0, 3'd7, 20, 1'b1, 1'b0);
    wait_sig("arst_run", 0, 1'b1, 100);
    wait_sig("arst_settle", 0, 1'b0, 200);
    #2 wb_rst_i = 1'b1;
    #1;
    check("arst_ctrl", {busy, error, result_valid, dut_reset, dut_stop_b, dut_counter_enable,
          dut_counter_load, dut_bypass_b, dut_control_b, dut_extra_inverter}, 10'b0001000110);
    check("arst_data", {dut_s_output_bit_b, dut_integration_time, dut_a_input}, 48'hFF_0000_0000_00);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    sb.delete();
    @(negedge wb_clk_i);

    snap();
    launch(3'd6, 3'd6, 25, 1'b1, 1'b0);
    wait_idle("recover", 1000);
    check_sweep("recover", 1, 3'd6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instrumented_adder_sequencer.md
Name: instrumented_adder_sequencer

Overview:
- On-chip initiator that drives the instrumented_adder control/counter interface, replacing CPU bit-banging over the logic analyser.
- On `start` it sweeps the sum bits `cfg_bit_first..cfg_bit_last`. For each bit it resets the DUT counters, loads the integration time, runs the ring oscillator until `done`, stops the ring, then presents the ring count on a valid/ready result port.
- Sits between a CPU-facing register block and instrumented_adder, in the same clock domain (`wb_clk_i`).

Parameters:
- RESET_CYCLES, 4, cycles `dut_reset` is held high per measurement (min 1).
- SETTLE_CYCLES, 8, cycles between stopping the ring and sampling `dut_ring_count` (min 1).
- TIMEOUT_MARGIN, 1024, extra cycles beyond `cfg_integration_time` allowed before timeout.

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- start  in  1  pulse; begins a sweep when IDLE, ignored otherwise
- abort  in  1  level; returns to IDLE from any state next cycle
- cfg_integration_time  in  32  integration counter load value
- cfg_a_input  in  8  adder `a` operand
- cfg_b_input  in  8  adder `b` operand
- cfg_bit_first  in  3  first swept bit
- cfg_bit_last  in  3  last swept bit
- cfg_bypass  in  1  bypass adder (non-inverted)
- cfg_extra_inverter  in  1  add extra inverter into ring
- cfg_control  in  1  enable control loop (non-inverted)
- busy  out  1  high when not IDLE
- error  out  1  sticky timeout flag, cleared on `start`
- dut_reset  out  1  DUT counter reset
- dut_stop_b  out  1  ring stop, inverted
- dut_extra_inverter  out  1  to DUT
- dut_bypass_b  out  1  to DUT
- dut_control_b  out  1  to DUT
- dut_a_input_ext_bit_b  out  8  to DUT
- dut_a_input_ring_bit_b  out  8  to DUT
- dut_s_output_bit_b  out  8  to DUT
- dut_counter_enable  out  1  to DUT
- dut_counter_load  out  1  to DUT
- dut_integration_time  out  32  to DUT
- dut_a_input  out  8  to DUT
- dut_b_input  out  8  to DUT
- dut_done  in  1  integration counter reached zero
- dut_ring_count  in  32  ring cycles / 2
- result_valid  out  1  result handshake
- result_ready  in  1  result handshake
- result_bit  out  3  bit measured
- result_count  out  32  captured ring count
- result_last  out  1  final bit of sweep

Behaviour:
- Reset: state IDLE; `dut_reset`=1; `dut_stop_b`=0; `dut_counter_enable`=0; `dut_counter_load`=0; all `_b` selects and `dut_bypass_b`/`dut_control_b` =1; data outputs 0; `busy`=0; `error`=0; `result_valid`=0.
- Config latch: on the `start` cycle, all `cfg_*` are latched; they are held constant for the whole sweep. The current bit register is loaded with `cfg_bit_first`. If `cfg_bit_last < cfg_bit_first`, a single measurement of `cfg_bit_first` is made.
- Selects: `dut_a_input_ring_bit_b` = `dut_s_output_bit_b` = ~(1<<bit). `dut_a_input_ext_bit_b` = 8'hFF. `_b` outputs carry the inverted latched cfg.
- RST: `dut_reset`=1 for RESET_CYCLES cycles, ring stopped, then LOAD.
- LOAD: `dut_counter_load`=1 for exactly 1 cycle, `dut_reset`=0, then RUN.
- RUN: `dut_stop_b`=1 and `dut_counter_enable`=1. A cycle counter starts at 0.
  - `dut_done`=1 -> next cycle `dut_stop_b`=0 and `dut_counter_enable`=0, go to SETTLE.
  - Counter reaches `cfg_integration_time`+TIMEOUT_MARGIN (33-bit, no wrap) without `done` -> set `error`, stop the ring, go to IDLE, no result for that bit.
- SETTLE: wait SETTLE_CYCLES, sample `dut_ring_count` into `result_count` on the last cycle, go to OUT.
- OUT: `result_valid`=1. `result_bit`, `result_count` and `result_last` are stable until `result_ready`. The transfer completes on a cycle where valid && ready.
  - After transfer: if bit==last (or single mode) -> IDLE, else bit+1 -> RST.
  - `result_ready` high before valid has no effect; no combinational ready->valid path.
- abort: highest priority. Next cycle the block is IDLE with reset-state outputs, `result_valid` dropped (any pending result is discarded) and `error` unchanged.
- start while busy is ignored. start and abort in the same cycle: abort wins.
- `wb_rst_i` mid-sweep asynchronously forces all outputs to their reset values.

Decomposition:
- Shared package `instr_adder_pkg`:
  - state enum (IDLE, RST, LOAD, RUN, SETTLE, OUT);
  - DUT select width (8) and bit-index width (3);
  - control-field bit positions matching the la1 control layout (reset 0, stop_b 1, extra_inv 2, bypass_b 3, control_b 4, counter_enable 5, counter_load 6), so the sequencer output can be muxed onto the same bus.
- One sub-module, `seq_delay_counter`: a loadable down-counter with zero flag, shared by RST, SETTLE and the RUN timeout (its own up-compare for RUN).

Test Plan:
- Single bit: first=last=3, integration=100, model asserts done after 100 enable cycles with count 0x1234 -> exactly one result, bit=3, count=0x1234, last=1; `s_output_bit_b`=8'hF7 during RUN.
- Sweep: first=0, last=7, ready always 1 -> 8 results with bits 0..7 in order, last=1 only on bit 7, RESET_CYCLES `dut_reset` pulses and a one-cycle `dut_counter_load` per bit.
- Backpressure: ready held low 20 cycles in OUT -> valid stays 1 with stable data, no next RST until the transfer.
- Timeout: model never asserts done, integration=10 -> `error`=1 after 10+1024 RUN cycles, `dut_stop_b`=0, IDLE, no result_valid.
- Abort in RUN and in OUT -> IDLE next cycle, valid=0, `dut_counter_enable`=0. A subsequent start runs normally and clears `error`.
- Async reset asserted in SETTLE -> outputs take reset values without a clock edge.
